vc_fifo_buffer: RTL and testbench
=================================

VC_FIFO_BUFFER -- requirements
Module: vc_fifo_buffer

Interface
REQ-001 Parameter WIDTH, default `TAM_FLIT, SHALL set the flit width in bits.
REQ-002 Parameter DEPTH, default `TAM_BUFFER, SHALL set the flits per virtual channel (VC); legal range >= 2, any integer, power of two not required.
REQ-003 Parameter NVC, default 2, SHALL set the VC count; legal range 1..8.
REQ-004 Derived widths SHALL be VCW = max(1, $clog2(NVC)) and CW = $clog2(DEPTH)+1.
REQ-005 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the reset: synchronous, active-high.
REQ-007 Port push, input, 1, SHALL be the write request.
REQ-008 Port push_vc, input, VCW, SHALL select the VC written.
REQ-009 Port tail, input, WIDTH, SHALL carry the flit written.
REQ-010 Port pull, input, 1, SHALL be the read request.
REQ-011 Port pull_vc, input, VCW, SHALL select the VC read.
REQ-012 Port head, output, NVC*WIDTH, SHALL present the oldest flit of VC v at bits [v*WIDTH +: WIDTH].
REQ-013 Port counter, output, NVC*CW, SHALL present the occupancy of VC v at bits [v*CW +: CW].
REQ-014 Port full, output, NVC, SHALL flag each VC at occupancy DEPTH.
REQ-015 Port empty, output, NVC, SHALL flag each VC at occupancy 0.
REQ-016 Port credit, output, NVC, SHALL pulse bit v for one cycle after an accepted pull on VC v.
REQ-017 Port err, output, NVC, SHALL hold the sticky per-VC error flags (see Configuration).

Function
REQ-018 Each VC SHALL be an independent circular buffer with a read pointer, a write pointer and a CW-bit occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-019 A pull SHALL be accepted iff pull=1 and empty[pull_vc]=0; an accepted pull advances that VC's read pointer.
REQ-020 A push SHALL be accepted iff push=1 and either full[push_vc]=0 or a pull is accepted on the same VC in the same cycle; an accepted push writes tail at the write pointer and advances it.
REQ-021 Push and pull on an empty VC in the same cycle: push accepted, pull rejected, occupancy becomes 1.
REQ-022 Accepted push and pull on the same VC: occupancy unchanged; on different VCs: each updates independently.
REQ-023 Occupancy SHALL increment on accepted push only, decrement on accepted pull only, and never leave 0..DEPTH.
REQ-024 full, empty and counter SHALL be registered-state-derived; they reflect an accepted operation in the cycle after it.
REQ-025 head SHALL be combinational from storage at each VC's read pointer; a flit pushed into an empty VC appears on head the following cycle; head is unspecified while empty.
REQ-026 credit[v] SHALL be registered: 1 in the cycle after an accepted pull on VC v, else 0.
REQ-027 Rejected requests SHALL change no state apart from err.
REQ-028 push_vc or pull_vc >= NVC SHALL be treated as a rejected request.

Reset
REQ-029 With reset=1 at a rising edge, all pointers and counters SHALL clear to 0, empty to all ones, full, credit and err to all zeros.
REQ-030 Reset SHALL take priority over push and pull in the same cycle; in-flight data is discarded and storage contents are not cleared.

Configuration
REQ-031 With macro FIFO_ERR_EN defined, err[v] SHALL set on a rejected push or rejected pull targeting VC v (excluding the REQ-021 case) and hold until reset.
REQ-032 Without FIFO_ERR_EN, err SHALL be tied to 0 and no error logic SHALL be synthesised; the port remains present.

Verification
REQ-033 Reset, then push 0xA1, 0xA2, 0xA3, 0xA4 into VC0 (DEPTH=4) -> full[0]=1, counter VC0=4, head VC0=0xA1, empty[1]=1.
REQ-034 VC0 full; push 0xB5 with pull on VC0 in the same cycle -> next cycle counter VC0=4, head VC0=0xA2; 0xB5 read out fourth.
REQ-035 Empty VC1; push 0x33 with pull on VC1 in the same cycle -> counter VC1=1, head VC1=0x33, credit[1]=0.
REQ-036 Eight push/pull pairs on VC1 crossing the pointer wrap -> output order identical to input order, credit[1] pulses eight times.
REQ-037 With FIFO_ERR_EN: pull on empty VC0 -> err=2'b01 held until reset; without the macro err stays 0.
REQ-038 Reset asserted while VC0 holds 3 flits and push=1 -> next cycle counter VC0=0, empty[0]=1, credit=0.

Source files
------------

// File: rtl/vc_fifo_buffer.sv
// ---------------------------------------------------------------------------
// vc_fifo_buffer
//
// Multi virtual-channel flit buffer. Each of the NVC channels is an
// independent circular FIFO of DEPTH flits, WIDTH bits each. One push and
// one pull may be issued per cycle, each naming the channel it targets.
//
// Optional feature: define FIFO_ERR_EN to build the sticky per-channel
// error flags. Without it, err is tied to zero and no error logic exists.
//
// Parameters
//   WIDTH  flit width in bits                  (default `TAM_FLIT)
//   DEPTH  flits per channel, >= 2             (default `TAM_BUFFER)
//   NVC    number of channels, 1..8            (default 2)
//   VCW    channel-select width, max(1, clog2(NVC))      (derived)
//   CW     occupancy count width, clog2(DEPTH)+1          (derived)
//
// Ports
//   clock    in   1          rising-edge clock
//   reset    in   1          synchronous active-high reset
//   push     in   1          write request
//   push_vc  in   VCW        channel written
//   tail     in   WIDTH      flit written
//   pull     in   1          read request
//   pull_vc  in   VCW        channel read
//   head     out  NVC*WIDTH  oldest flit of channel v at [v*WIDTH +: WIDTH]
//   counter  out  NVC*CW     occupancy of channel v at [v*CW +: CW]
//   full     out  NVC        channel at occupancy DEPTH
//   empty    out  NVC        channel at occupancy 0
//   credit   out  NVC        one-cycle pulse after an accepted pull
//   err      out  NVC        sticky rejected-request flags
// ---------------------------------------------------------------------------

`ifndef TAM_FLIT
`define TAM_FLIT 8
`endif

`ifndef TAM_BUFFER
`define TAM_BUFFER 4
`endif

module vc_fifo_buffer #(
  parameter int WIDTH = `TAM_FLIT,
  parameter int DEPTH = `TAM_BUFFER,
  parameter int NVC   = 2,
  localparam int VCW  = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [VCW-1:0]       push_vc,
  input  logic [WIDTH-1:0]     tail,
  input  logic                 pull,
  input  logic [VCW-1:0]       pull_vc,
  output logic [NVC*WIDTH-1:0] head,
  output logic [NVC*CW-1:0]    counter,
  output logic [NVC-1:0]       full,
  output logic [NVC-1:0]       empty,
  output logic [NVC-1:0]       credit,
  output logic [NVC-1:0]       err
);

  // Pointer width; a DEPTH of exactly 2 still needs one bit.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  // One extra bit so that NVC itself (e.g. 8 with VCW=3) is representable.
  localparam logic [VCW:0]   NVC_LIM  = (VCW + 1)'(NVC);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A channel select beyond NVC-1 never matches any channel, so such a
  // request is rejected and touches no state.
  logic push_in_range;
  logic pull_in_range;

  assign push_in_range = ({1'b0, push_vc} < NVC_LIM);
  assign pull_in_range = ({1'b0, pull_vc} < NVC_LIM);

  generate
    for (genvar gi = 0; gi < NVC; gi++) begin : g_vc
      localparam logic [VCW-1:0] VC_ID = VCW'(gi);

      logic [WIDTH-1:0] mem_reg [DEPTH];

      logic [PW-1:0] rd_ptr_reg;
      logic [PW-1:0] rd_ptr_next;
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] wr_ptr_next;
      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;
      logic          empty_reg;
      logic          full_reg;
      logic          credit_reg;

      logic push_hit;
      logic pull_hit;
      logic push_ok;
      logic pull_ok;

      assign push_hit = push & push_in_range & (push_vc == VC_ID);
      assign pull_hit = pull & pull_in_range & (pull_vc == VC_ID);

      // Pull is judged first: a simultaneous pull on a full channel frees
      // the slot the push needs. A pull on an empty channel is never
      // accepted, even when a push lands in the same cycle.
      assign pull_ok = pull_hit & ~empty_reg;
      assign push_ok = push_hit & (~full_reg | pull_ok);

      always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (pull_ok) begin
          rd_ptr_next = ptr_adv(rd_ptr_reg);
        end
        if (push_ok) begin
          wr_ptr_next = ptr_adv(wr_ptr_reg);
        end

        // Simultaneous accepted push and pull leave occupancy unchanged.
        if (push_ok && !pull_ok) begin
          count_next = count_reg + CNT_ONE;
        end else if (pull_ok && !push_ok) begin
          count_next = count_reg - CNT_ONE;
        end
      end

      // Flags are registered from the next count so they line up with
      // count_reg exactly, without a compare on the output path.
      always_ff @(posedge clock) begin
        if (reset) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          empty_reg  <= 1'b1;
          full_reg   <= 1'b0;
          credit_reg <= 1'b0;
        end else begin
          rd_ptr_reg <= rd_ptr_next;
          wr_ptr_reg <= wr_ptr_next;
          count_reg  <= count_next;
          empty_reg  <= (count_next == '0);
          full_reg   <= (count_next == CNT_FULL);
          credit_reg <= pull_ok;
        end
      end

      // Storage is never cleared; reset only drops the write in progress.
      always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
          mem_reg[wr_ptr_reg] <= tail;
        end
      end

      // Head is an asynchronous read at the read pointer so a flit is
      // visible the cycle after it is written into an empty channel.
      assign head[gi*WIDTH +: WIDTH] = mem_reg[rd_ptr_reg];
      assign counter[gi*CW +: CW]    = count_reg;
      assign full[gi]                = full_reg;
      assign empty[gi]               = empty_reg;
      assign credit[gi]              = credit_reg;

`ifdef FIFO_ERR_EN
      logic err_reg;
      logic push_bad;
      logic pull_bad;

      // A pull on an empty channel that coincides with an accepted push on
      // the same channel is the normal bypass-free case, not an error.
      assign push_bad = push_hit & ~push_ok;
      assign pull_bad = pull_hit & ~pull_ok & ~push_ok;

      always_ff @(posedge clock) begin
        if (reset) begin
          err_reg <= 1'b0;
        end else if (push_bad || pull_bad) begin
          err_reg <= 1'b1;
        end
      end

      assign err[gi] = err_reg;
`else
      assign err[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo_buffer
//
// Directed bench for vc_fifo_buffer with WIDTH=8, DEPTH=4, NVC=2. A
// per-channel scoreboard queue receives every flit the model expects to be
// accepted; flits are popped and compared against head when a pull is
// accepted. After every cycle the occupancy, flags, credit and err are
// compared against the model.
// ---------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_vc_fifo_buffer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int CWB = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            push;
  logic [0:0]      push_vc;
  logic [W-1:0]    tail;
  logic            pull;
  logic [0:0]      pull_vc;
  logic [N*W-1:0]  head;
  logic [N*CWB-1:0] counter;
  logic [N-1:0]    full;
  logic [N-1:0]    empty;
  logic [N-1:0]    credit;
  logic [N-1:0]    err;

  vc_fifo_buffer #(.WIDTH(W), .DEPTH(D), .NVC(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .push_vc (push_vc),
    .tail    (tail),
    .pull    (pull),
    .pull_vc (pull_vc),
    .head    (head),
    .counter (counter),
    .full    (full),
    .empty   (empty),
    .credit  (credit),
    .err     (err)
  );

  always #5 clock = ~clock;

  // Scoreboard and model state
  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];
  logic [N-1:0] credit_m;
  logic [N-1:0] err_m;
  int n_checks = 0;
  int n_fail   = 0;
  int credit1_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input logic v);
    return v ? sb1.size() : sb0.size();
  endfunction

  task automatic post_check(input string tag);
    logic [N*CWB-1:0] cnt_e;
    logic [N-1:0]     full_e;
    logic [N-1:0]     empty_e;
    logic [N-1:0]     err_e;
    cnt_e   = {CWB'(sb1.size()), CWB'(sb0.size())};
    full_e  = {sb1.size() == D, sb0.size() == D};
    empty_e = {sb1.size() == 0, sb0.size() == 0};
`ifdef FIFO_ERR_EN
    err_e = err_m;
`else
    err_e = '0;
`endif
    check({tag, ".counter"}, 32'(counter), 32'(cnt_e));
    check({tag, ".full"},    32'(full),    32'(full_e));
    check({tag, ".empty"},   32'(empty),   32'(empty_e));
    check({tag, ".credit"},  32'(credit),  32'(credit_m));
    check({tag, ".err"},     32'(err),     32'(err_e));
    if (sb0.size() > 0) check({tag, ".head0"}, 32'(head[0 +: W]), 32'(sb0[0]));
    if (sb1.size() > 0) check({tag, ".head1"}, 32'(head[W +: W]), 32'(sb1[0]));
    $display("[%0t] %s cnt=%0h full=%b empty=%b credit=%b err=%b",
             $time, tag, counter, full, empty, credit, err);
  endtask

  // One cycle of traffic; the model decides acceptance from its own queues.
  task automatic op(input string tag, input logic ph, input logic pv, input logic [W-1:0] d,
                    input logic pl, input logic lv);
    logic pull_acc;
    logic push_acc;
    logic [W-1:0] exp_flit;
    pull_acc = pl && (sb_size(lv) > 0);
    push_acc = ph && ((sb_size(pv) < D) || (pull_acc && (pv == lv)));
    if (pull_acc) begin
      exp_flit = lv ? sb1.pop_front() : sb0.pop_front();
      check({tag, ".pop"}, 32'(head[lv*W +: W]), 32'(exp_flit));
    end
    if (push_acc) begin
      if (pv) sb1.push_back(d); else sb0.push_back(d);
    end
    if (ph && !push_acc) err_m[pv] = 1'b1;
    if (pl && !pull_acc && !(ph && push_acc && pv == lv)) err_m[lv] = 1'b1;
    credit_m = '0;
    if (pull_acc) credit_m[lv] = 1'b1;

    push = ph; push_vc = pv; tail = d; pull = pl; pull_vc = lv;
    @(posedge clock);
    #1;
    push = 1'b0; pull = 1'b0;
    post_check(tag);
  endtask

  task automatic do_reset(input string tag, input logic ph, input logic pl);
    reset = 1'b1; push = ph; push_vc = 1'b0; tail = 8'hEE; pull = pl; pull_vc = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0; push = 1'b0; pull = 1'b0;
    sb0.delete();
    sb1.delete();
    credit_m = '0;
    err_m    = '0;
    post_check(tag);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; push_vc = 1'b0; tail = '0; pull = 1'b0; pull_vc = 1'b0;
    credit_m = '0; err_m = '0;
    @(posedge clock);
    #1;
    do_reset("reset", 1'b0, 1'b0);

    // Fill VC0 to capacity
    op("fill0_a1", 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    op("fill0_a2", 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    op("fill0_a3", 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
    op("fill0_a4", 1'b1, 1'b0, 8'hA4, 1'b0, 1'b0);
    check("full_head0", 32'(head[0 +: W]), 32'h0000_00A1);

    // Push into a full channel alongside a pull on it
    op("full_pushpull", 1'b1, 1'b0, 8'hB5, 1'b1, 1'b0);
    check("full_pp_head0", 32'(head[0 +: W]), 32'h0000_00A2);

    // Drain VC0; the B5 flit must come out fourth
    for (int i = 0; i < 4; i++) op("drain0", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Push and pull on an empty VC1 in the same cycle
    op("empty_pushpull1", 1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
    check("empty_pp_head1", 32'(head[W +: W]), 32'h0000_0033);
    op("drain1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Prime VC1 then run eight push/pull pairs across the pointer wrap
    op("prime1", 1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
    credit1_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      op("wrap1", 1'b1, 1'b1, 8'h41 + 8'(i), 1'b1, 1'b1);
      if (credit[1]) credit1_pulses++;
    end
    check("wrap1_credit_pulses", 32'(credit1_pulses), 32'd8);
    op("wrap1_last", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Independent traffic on the two channels in one cycle
    op("cross_a", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    op("cross_b", 1'b1, 1'b1, 8'h6B, 1'b1, 1'b0);
    op("cross_c", 1'b1, 1'b0, 8'h7C, 1'b1, 1'b1);
    op("cross_d", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Error flags: pull on empty VC0, held over idle cycles
    op("err_pull_empty0", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("err_hold_a", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    op("err_hold_b", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset("err_cleared", 1'b0, 1'b0);

    // Overflow push on VC1
    for (int i = 0; i < 4; i++) op("fill1", 1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    op("overflow1", 1'b1, 1'b1, 8'hCF, 1'b0, 1'b0);
    op("drain1_first", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset while VC0 holds three flits and a push/pull is requested
    do_reset("pre_rst", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op("load0", 1'b1, 1'b0, 8'hD0 + 8'(i), 1'b0, 1'b0);
    do_reset("reset_with_push", 1'b1, 1'b1);
    op("post_rst_push", 1'b1, 1'b0, 8'hE1, 1'b0, 1'b0);
    op("post_rst_pull", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
